// File: rtl/updown_mod_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter_n
// Brief    : DIGITS-digit modulo-RADIX synchronous up/down counter with count
//            enable, parallel load and enable-qualified carry/borrow output.
//            Optional macro UPDOWN_COUNTER_SAT_EN: saturate at terminal count
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter_n #(
  parameter  int RADIX  = 10,
  parameter  int DIGITS = 2,
  localparam int DW     = $clog2(RADIX)
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 M,
  input  logic                 en,
  input  logic                 ld,
  input  logic [DIGITS*DW-1:0] d,
  output logic [DIGITS*DW-1:0] Q,
  output logic [DIGITS*DW-1:0] Qbar,
  output logic                 tc,
  output logic                 cout
);

  localparam logic [DW-1:0] c_DIG_MAX = DW'(RADIX - 1);
  localparam logic [DW:0]   c_RADIX_X = (DW + 1)'(RADIX);

  logic [DIGITS*DW-1:0] r_q;
  logic [DIGITS*DW-1:0] r_qbar;
  logic [DIGITS*DW-1:0] w_next;
  logic [DIGITS-1:0]    w_hit;
  logic [DIGITS:0]      w_ripple;
  logic                 w_term;
  logic                 w_step;

  // w_ripple[k] is high when every digit below k sits at its roll-over value
  always_comb begin : p_ripple
    logic v_run;
    v_run = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      w_ripple[k] = v_run;
      v_run       = v_run & w_hit[k];
    end
    w_ripple[DIGITS] = v_run;
  end

  assign w_term = w_ripple[DIGITS];

`ifdef UPDOWN_COUNTER_SAT_EN
  assign w_step = en & ~w_term;
`else
  assign w_step = en;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [DW-1:0] w_cur;
    logic [DW-1:0] w_ld;
    logic [DW-1:0] w_ld_ok;
    logic [DW-1:0] w_upd;

    assign w_cur    = r_q[k*DW +: DW];
    assign w_ld     = d[k*DW +: DW];
    assign w_hit[k] = M ? (w_cur == '0) : (w_cur == c_DIG_MAX);

    // Out-of-range load digits are forced to zero so Q never leaves 0..RADIX-1
    assign w_ld_ok  = ({1'b0, w_ld} < c_RADIX_X) ? w_ld : '0;

    assign w_upd    = M ? ((w_cur == '0)        ? c_DIG_MAX : w_cur - DW'(1))
                        : ((w_cur == c_DIG_MAX) ? '0        : w_cur + DW'(1));

    assign w_next[k*DW +: DW] = ld                     ? w_ld_ok :
                                (w_step & w_ripple[k]) ? w_upd   :
                                                         w_cur;
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_q    <= '0;
      r_qbar <= '1;
    end else begin
      r_q    <= w_next;
      r_qbar <= ~w_next;
    end
  end

  assign Q    = r_q;
  assign Qbar = r_qbar;
  assign tc   = w_term & ~R;
  assign cout = w_term & en & ~R;

endmodule
`default_nettype wire

// File: doc/updown_mod_counter_n.md
Name: updown_mod_counter_n

Overview:
- Parametrised successor to the single-digit mod-10 up/down counter.
- Multi-digit synchronous up/down counter: DIGITS cascaded digits, each modulo RADIX (default two BCD digits, 00..99).
- Adds count enable, parallel load and an enable-qualified carry/borrow output, so counters cascade into wider display/timer chains.
- Direction convention is kept: M=0 counts up, M=1 counts down.

Parameters:
- RADIX, 10, modulus of each digit; legal range 2..16.
- DIGITS, 2, number of cascaded digits; legal range 1..8.
- DW, $clog2(RADIX) (derived, not overridable), bits per digit.

Ports:
- clk  input  1  rising-edge clock.
- R  input  1  asynchronous active-high reset.
- M  input  1  direction: 0 = up, 1 = down.
- en  input  1  count enable; hold when low.
- ld  input  1  synchronous parallel load.
- d  input  DIGITS*DW  load value; digit k at bits [k*DW +: DW], digit 0 least significant.
- Q  output  DIGITS*DW  count value, same packing as d.
- Qbar  output  DIGITS*DW  bitwise inverse of Q.
- tc  output  1  terminal count, not gated by en.
- cout  output  1  tc & en & !R; carry (up) or borrow (down) for the next stage.

Behaviour:
- Reset: R high forces Q=0 and Qbar=all ones immediately (asynchronous). tc and cout are 0 while R is high.
  - First count happens on the first rising clk edge after R deasserts.
  - R asserted mid-count aborts any load or count in progress. There is no recovery state.
- Priority at each rising clk edge: R, then ld, then en, then hold.
- ld=1: Q <= d, whatever en and M are.
  - Any load digit >= RADIX is stored as 0; the other digits load unchanged.
- ld=0, en=1, M=0 (up):
  - Digit 0 increments.
  - Digit k increments only when every lower digit is RADIX-1 on that edge.
  - A digit at RADIX-1 that increments wraps to 0.
- ld=0, en=1, M=1 (down):
  - Digit 0 decrements.
  - Digit k decrements only when every lower digit is 0 on that edge.
  - A digit at 0 that decrements wraps to RADIX-1.
- Full wrap: up from all-(RADIX-1) gives all 0; down from all 0 gives all-(RADIX-1). Both happen in one cycle.
- en=0 and ld=0: Q holds.
- Latency: Q updates on the same edge that samples en, ld, M and d. There is no pipeline.
- tc (combinational):
  - M=0: 1 when every digit is RADIX-1.
  - M=1: 1 when every digit is 0.
- cout (combinational) = tc & en & !R. An M change is seen in the same cycle.
- Q digits never hold a value >= RADIX.
- Next-state logic is a per-digit increment/decrement with a ripple-enable chain, built in a generate loop over DIGITS.
- Q and Qbar come straight from flops; no combinational path from inputs to Q or Qbar.

Optional Feature:
- Macro: UPDOWN_COUNTER_SAT_EN.
- Defined:
  - Counting saturates instead of wrapping. Up at all-(RADIX-1) holds; down at all 0 holds.
  - cout still asserts at terminal count with en=1.
  - ld behaves as without the macro.
- Not defined: modulo wrap as in Behaviour.

Test Plan:
1. Reset: assert R between clock edges with Q=37 -> Q=00 and Qbar=all ones with no clk edge; tc=0, cout=0 while R=1.
2. Up count, RADIX=10, DIGITS=2, M=0, en=1 from 00, 100 edges:
   - Q after edges 9, 10, 99, 100 = 09, 10, 99, 00.
   - cout=1 only during the cycle Q=99.
3. Down count, M=1, en=1 from 00:
   - Next edge gives Q=99 (wrap); cout=1 during the cycle Q=00.
   - From 10, one edge gives 09.
4. Load and priority:
   - ld=1, en=1, d=0x47 -> Q=47, no count that edge.
   - d=0x5C -> Q=50 (invalid digit zeroed).
   - ld, en and R all high -> Q=00.
5. Enable and direction:
   - en=0 for 5 edges at Q=42 -> Q stays 42; cout=0 even when Q=99 with en=0.
   - Toggle M at Q=00 -> tc goes 0 to 1 in the same cycle.
6. Generics:
   - RADIX=16, DIGITS=1, up from 0xE -> 0xF then 0x0.
   - With UPDOWN_COUNTER_SAT_EN, up from 0xF holds 0xF.
